// File: rtl/debounce_pkg.sv
// debounce_pkg: width helpers and default constants shared by the debounce bank.
package debounce_pkg;
    localparam int DEFAULT_TICK_CYCLES    = 500000;
    localparam int DEFAULT_STABLE_SAMPLES = 4;

    function automatic int tcnt_width(input int tick_cycles);
        return (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
    endfunction

    function automatic int scnt_width(input int stable_samples);
        return (stable_samples > 0) ? $clog2(stable_samples + 1) : 1;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced input with rise/fall pulses.
// Optional 2-flop input synchroniser enabled by DEBOUNCE_SYNC_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter logic INIT           = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int SW = scnt_width(STABLE_SAMPLES);

    logic          sample;
    logic          flip;
    logic [SW-1:0] scnt;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk) begin
        if (!reset) sync <= {2{INIT}};
        else        sync <= {sync[0], raw};
    end
    assign sample = sync[1];
`else
    assign sample = raw;
`endif

    assign flip = tick && (sample != level) && (scnt == SW'(STABLE_SAMPLES - 1));

    // Any sample matching the current level restarts qualification.
    always_ff @(posedge clk) begin
        if (!reset) begin
            level <= INIT;
            scnt  <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= flip && !level;
            fall <= flip && level;
            if (tick) begin
                level <= level ^ flip;
                scnt  <= (sample == level || flip) ? '0 : scnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel debouncer sharing one sample-tick generator.
// Define DEBOUNCE_SYNC_EN to synchronise asynchronous raw inputs.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS       = 4,
    parameter int                  TICK_CYCLES    = DEFAULT_TICK_CYCLES,
    parameter int                  STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter logic [CHANNELS-1:0] INIT_LEVEL     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);
    localparam int TW = tcnt_width(TICK_CYCLES);

    logic [TW-1:0] tcnt;

    // tick is registered: it rises on the edge where tcnt enters TICK_CYCLES-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tcnt <= (tcnt == TW'(TICK_CYCLES - 1)) ? '0 : tcnt + 1'b1;
            tick <= (tcnt == TW'(TICK_CYCLES - 2));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .INIT          (INIT_LEVEL[g])
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .raw  (raw_in[g]),
            .level(level[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end
endmodule
